// File: rtl/fp_wb_pkg.sv
// Shared types and flag bit positions for the fpadd writeback stage.
package fp_wb_pkg;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int WB_TAG_W = 4;

  typedef logic [4:0] fflags_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} wb_state_t;

  // Default-width view of one buffered result; the top rebuilds this with its own TAG_W.
  typedef struct packed {
    logic [63:0]         result;
    fflags_t             flags;
    logic                denorm;
    logic [WB_TAG_W-1:0] tag;
  } wb_entry_t;

endpackage

// File: rtl/fpadd_wb_stage_if.sv
// Producer/consumer handshake bundle around the fpadd writeback stage.
interface fpadd_wb_stage_if
  import fp_wb_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_result;
  fflags_t          in_flags;
  logic             in_denorm;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  fflags_t          out_flags;
  logic             out_denorm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_result, in_flags, in_denorm, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_denorm, out_tag
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_denorm, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_denorm, out_tag
  );
endinterface

// File: rtl/fp_wb_skid.sv
// Two-entry skid buffer with registered in_ready and flush.
//  state   | meaning
//  S_EMPTY | nothing buffered
//  S_ONE   | head valid, spare free
//  S_FULL  | head and spare valid, in_ready low
module fp_wb_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [W-1:0] head;
  logic [W-1:0] spare;
  logic         accept;
  logic         retire;

  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign out_valid = (state != S_EMPTY);
  assign out_data  = head;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (accept) state_nxt = S_ONE;
      S_ONE: begin
        if (accept && !retire)      state_nxt = S_FULL;
        else if (retire && !accept) state_nxt = S_EMPTY;
      end
      S_FULL:  if (retire) state_nxt = S_ONE;
      default: state_nxt = S_EMPTY;
    endcase
    if (flush) state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_EMPTY;
      in_ready <= 1'b1;
      head     <= '0;
      spare    <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != S_FULL);
      // A flushed cycle writes nothing, so an accept in that cycle is dropped.
      if (!flush) begin
        case (state)
          S_EMPTY: if (accept) head <= in_data;
          S_ONE: begin
            if (accept && retire) head  <= in_data;
            else if (accept)      spare <= in_data;
          end
          S_FULL:  if (retire) head <= spare;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/fpadd_wb_stage.sv
// fpadd writeback: skid-buffers results, accumulates sticky fflags, traps and counts retires.
module fpadd_wb_stage
  import fp_wb_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  fpadd_wb_stage_if.slave      wb,
  input  logic                 flush,
  output fflags_t              fflags,
  input  logic                 fflags_wr,
  input  fflags_t              fflags_wdata,
  input  logic                 fflags_clr,
  input  fflags_t              exc_en,
  output logic                 exc_trap,
  output logic [CNT_W-1:0]     retired_cnt
);

  typedef struct packed {
    logic [63:0]      result;
    fflags_t          flags;
    logic             denorm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t  in_entry;
  entry_t  head;
  logic    retire;
  fflags_t retire_flags;

  assign in_entry = {wb.in_result, wb.in_flags, wb.in_denorm, wb.in_tag};

  fp_wb_skid #(
    .W ($bits(entry_t))
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (wb.in_valid),
    .in_ready  (wb.in_ready),
    .in_data   (in_entry),
    .out_valid (wb.out_valid),
    .out_ready (wb.out_ready),
    .out_data  (head)
  );

  assign wb.out_result = head.result;
  assign wb.out_flags  = head.flags;
  assign wb.out_denorm = head.denorm;
  assign wb.out_tag    = head.tag;

  assign retire       = wb.out_valid & wb.out_ready;
  assign retire_flags = wb.out_flags & {5{retire}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      fflags      <= '0;
      exc_trap    <= 1'b0;
      retired_cnt <= '0;
    end else begin
      // A software write wins outright; clear still lets this cycle's retire flags through.
      if (fflags_wr)       fflags <= fflags_wdata;
      else if (fflags_clr) fflags <= retire_flags;
      else                 fflags <= fflags | retire_flags;
      exc_trap    <= |(retire_flags & exc_en);
      retired_cnt <= retired_cnt + CNT_W'(retire);
    end
  end

endmodule
